// File: rtl/instr_issue_queue.sv
// RV32 front-end issue queue: decodes raw instruction words into the execute core's
// field interface, buffers them, and holds each one on the outputs for HOLD_CYCLES clocks.
module instr_issue_queue #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    output logic [6:0]                 opcode,
    output logic [4:0]                 rd,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic [11:0]                imm12,
    output logic                       issue_valid,
    output logic                       issue_start,
    output logic [7:0]                 illegal_count,
    output logic [15:0]                retired_count,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int NDEC = 6;

    // Decode table, entry 0 in the low slice: ADD, SUBS, LESSTHAN, ADDI, LESSTHANI, SUBSI
    localparam logic [NDEC*7-1:0] T_OP   = {7'b0001011, 7'b0010011, 7'b0010011,
                                            7'b0110011, 7'b0110011, 7'b0110011};
    localparam logic [NDEC*3-1:0] T_F3   = {3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000};
    localparam logic [NDEC*7-1:0] T_F7   = {7'b0000000, 7'b0000000, 7'b0000000,
                                            7'b0000000, 7'b0100000, 7'b0000000};
    localparam logic [NDEC-1:0]   T_RTYP = 6'b000111;
    localparam logic [NDEC*7-1:0] T_CODE = {7'd12, 7'd13, 7'd11, 7'd3, 7'd2, 7'd1};

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } entry_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [NDEC-1:0] dec_hit;
    logic [6:0]      dec_op;
    logic            dec_legal;
    logic            dec_rtype;
    entry_t          dec_entry;

    generate
        for (genvar gi = 0; gi < NDEC; gi++) begin : g_dec
            assign dec_hit[gi] = (in_instr[6:0] == T_OP[gi*7 +: 7]) &&
                                 (in_instr[14:12] == T_F3[gi*3 +: 3]) &&
                                 (!T_RTYP[gi] || (in_instr[31:25] == T_F7[gi*7 +: 7]));
        end
    endgenerate

    always_comb begin
        dec_op = 7'd0;
        for (int i = 0; i < NDEC; i++) begin
            if (dec_hit[i]) dec_op = dec_op | T_CODE[i*7 +: 7];
        end
        dec_legal     = |dec_hit;
        dec_rtype     = |(dec_hit & T_RTYP);
        dec_entry.op  = dec_op;
        dec_entry.rd  = in_instr[11:7];
        dec_entry.rs1 = in_instr[19:15];
        dec_entry.rs2 = dec_rtype ? in_instr[24:20] : 5'd0;
        dec_entry.imm = dec_rtype ? 12'd0 : in_instr[31:20];
    end

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic          fifo_empty, fifo_full;
    logic          accept, push, pop;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign in_ready   = !reset && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && dec_legal;
    assign fifo_level = wr_ptr_reg - rd_ptr_reg;

    // Storage is left unreset so it maps onto RAM; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= dec_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          retire, go_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        retire     = 1'b0;
        go_idle    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                    cnt_next   = '0;
                end
            end
            ISSUE: begin
                if (cnt_reg == CW'(HOLD_CYCLES - 1)) begin
                    retire   = 1'b1;
                    cnt_next = '0;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                        go_idle    = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    entry_t      head_reg;
    logic        valid_reg, start_reg;
    logic [7:0]  illegal_reg;
    logic [15:0] retired_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg    <= '0;
            valid_reg   <= 1'b0;
            start_reg   <= 1'b0;
            illegal_reg <= 8'd0;
            retired_reg <= 16'd0;
        end else begin
            start_reg <= pop;
            if (pop) begin
                head_reg  <= mem[rd_ptr_reg[AW-1:0]];
                valid_reg <= 1'b1;
            end else if (go_idle) begin
                head_reg.op <= 7'd0;
                valid_reg   <= 1'b0;
            end
            if (retire) retired_reg <= retired_reg + 16'd1;
            if (accept && !dec_legal && illegal_reg != 8'hFF) illegal_reg <= illegal_reg + 8'd1;
        end
    end

    assign opcode        = head_reg.op;
    assign rd            = head_reg.rd;
    assign rs1           = head_reg.rs1;
    assign rs2           = head_reg.rs2;
    assign imm12         = head_reg.imm;
    assign issue_valid   = valid_reg;
    assign issue_start   = start_reg;
    assign illegal_count = illegal_reg;
    assign retired_count = retired_reg;
endmodule
